// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the MAR -> SRAM -> MDR memory interface.
// Owns the SRAM strobes and the shared bidirectional data bus.
module mem_arbiter #(
    parameter int AW           = 11,
    parameter int DW           = 16,
    parameter int WRITE_CYCLES = 2,
    parameter int READ_CYCLES  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_we0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_gnt0,
    output logic          o_done0,
    input  logic          i_req1,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_gnt1,
    output logic          o_done1,
    output logic [DW-1:0] o_rdata,
    output logic          o_busy,
    output logic [AW-1:0] o_memAdd,
    inout  wire  [DW-1:0] io_memData,
    output logic          o_nMemOut,
    output logic          o_nMemWrite
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam int MAXC = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] R_LAST = CW'(READ_CYCLES - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic          r_lastGnt;
    logic          r_port;
    logic          r_we;
    logic [AW-1:0] r_memAdd;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [CW-1:0] r_cnt;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_done0;
    logic          r_done1;

    logic          w_req0Valid;
    logic          w_req1Valid;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_grantAny;
    logic          w_wLast;
    logic          w_rLast;
    logic          w_busDrive;

    // A port finishing this cycle is masked so its lingering req cannot re-win.
    // The last-granted pointer only moves when both ports actually contend.
    always_comb begin
        w_req0Valid = i_req0 & ~r_done0;
        w_req1Valid = i_req1 & ~r_done1;
        w_grant1    = w_req1Valid & (~w_req0Valid | ~r_lastGnt);
        w_grant0    = w_req0Valid & ~w_grant1;
        w_grantAny  = (r_state == IDLE) & (w_grant0 | w_grant1);
        w_wLast     = (r_cnt == W_LAST);
        w_rLast     = (r_cnt == R_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grantAny) w_nextState = ADDR;
            ADDR:    w_nextState = r_we ? WRITE : READ;
            WRITE:   if (w_wLast) w_nextState = IDLE;
            READ:    if (w_rLast) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != IDLE);
        o_nMemWrite = (r_state != WRITE);
        o_nMemOut   = (r_state != READ);
        w_busDrive  = (r_state == WRITE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lastGnt <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_memAdd  <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grantAny) begin
                        r_port   <= w_grant1;
                        r_we     <= w_grant1 ? i_we1 : i_we0;
                        r_memAdd <= w_grant1 ? i_addr1 : i_addr0;
                        r_wdata  <= w_grant1 ? i_wdata1 : i_wdata0;
                        r_gnt0   <= w_grant0;
                        r_gnt1   <= w_grant1;
                        if (w_req0Valid && w_req1Valid) begin
                            r_lastGnt <= w_grant1;
                        end
                    end
                end
                ADDR: begin
                    r_cnt <= '0;
                end
                WRITE: begin
                    if (w_wLast) begin
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (w_rLast) begin
                        r_rdata <= io_memData;
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign io_memData = w_busDrive ? r_wdata : {DW{1'bz}};
    assign o_memAdd   = r_memAdd;
    assign o_rdata    = r_rdata;
    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_done0    = r_done0;
    assign o_done1    = r_done1;

    // Bus safety: the SRAM must never see both strobes, and grants are exclusive.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !((o_nMemOut == 1'b0) && (o_nMemWrite == 1'b0)));
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_gnt0 && o_gnt1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a small SRAM model sits on the shared bus,
// each task drives one scenario and compares against hand-computed values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [10:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, done0, gnt1, done1;
    logic [15:0] rdata;
    logic        busy;
    logic [10:0] memAdd;
    wire  [15:0] memData;
    logic        nMemOut, nMemWrite;
    logic        probeOn;
    logic [15:0] sram [0:2047];
    int          testsRun;
    int          testsFailed;

    always #5 clk = ~clk;

    // SRAM drives the bus during reads; the probe lets the bench prove the DUT released it.
    assign memData = (!nMemOut) ? sram[memAdd] : (probeOn ? 16'h1234 : 16'hzzzz);

    always @(posedge clk) begin
        if (!nMemWrite) sram[memAdd] <= memData;
    end

    mem_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req0),
        .i_we0       (we0),
        .i_addr0     (addr0),
        .i_wdata0    (wdata0),
        .o_gnt0      (gnt0),
        .o_done0     (done0),
        .i_req1      (req1),
        .i_we1       (we1),
        .i_addr1     (addr1),
        .i_wdata1    (wdata1),
        .o_gnt1      (gnt1),
        .o_done1     (done1),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_memAdd    (memAdd),
        .io_memData  (memData),
        .o_nMemOut   (nMemOut),
        .o_nMemWrite (nMemWrite)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [10:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    task automatic applyReset;
        applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 11'h0, 16'h0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        applyReset;
        testsRun++;
        if ({nMemOut, nMemWrite} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b expected 11", {nMemOut, nMemWrite});
        end
        testsRun++;
        if (memAdd !== 11'h000 || rdata !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_regs: memAdd=%h rdata=%h expected 000/0000", memAdd, rdata);
        end
        testsRun++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b00000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: gnt0,gnt1,done0,done1,busy=%b expected 00000",
                     {gnt0, gnt1, done0, done1, busy});
        end
        probeOn = 1'b1;
        #1;
        testsRun++;
        if (memData !== 16'h1234) begin
            testsFailed++;
            $display("[TB] FAIL reset_bus_released: got %h expected 1234", memData);
        end
        probeOn = 1'b0;
    endtask

    task automatic test_write;
        applyStimulus(0, 1'b1, 1'b1, 11'h005, 16'hBEEF);
        tick;
        testsRun++;
        if ({gnt0, gnt1, busy, nMemWrite, nMemOut} !== 5'b10111 || memAdd !== 11'h005) begin
            testsFailed++;
            $display("[TB] FAIL write_cycle1: gnt0,gnt1,busy,nW,nO=%b memAdd=%h expected 10111/005",
                     {gnt0, gnt1, busy, nMemWrite, nMemOut}, memAdd);
        end
        for (int c = 2; c <= 3; c++) begin
            tick;
            testsRun++;
            if ({nMemWrite, nMemOut} !== 2'b01 || memData !== 16'hBEEF || memAdd !== 11'h005
                || gnt0 !== 1'b0 || done0 !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL write_data_c%0d: nW,nO=%b memData=%h memAdd=%h gnt0=%b done0=%b expected 01/BEEF/005/0/0",
                         c, {nMemWrite, nMemOut}, memData, memAdd, gnt0, done0);
            end
        end
        tick;
        testsRun++;
        if ({done0, done1, busy, nMemWrite} !== 4'b1001 || rdata !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL write_done: done0,done1,busy,nW=%b rdata=%h expected 1001/0000",
                     {done0, done1, busy, nMemWrite}, rdata);
        end
        applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0);
        tick;
        testsRun++;
        if ({done0, gnt0, busy} !== 3'b000 || memAdd !== 11'h005) begin
            testsFailed++;
            $display("[TB] FAIL write_after: done0,gnt0,busy=%b memAdd=%h expected 000/005",
                     {done0, gnt0, busy}, memAdd);
        end
    endtask

    task automatic test_read_back;
        applyStimulus(1, 1'b1, 1'b0, 11'h005, 16'h0);
        tick;
        testsRun++;
        if ({gnt0, gnt1} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL read_gnt: gnt0,gnt1=%b expected 01", {gnt0, gnt1});
        end
        for (int c = 2; c <= 3; c++) begin
            tick;
            testsRun++;
            if ({nMemOut, nMemWrite} !== 2'b01 || done1 !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL read_strobe_c%0d: nO,nW=%b done1=%b expected 01/0",
                         c, {nMemOut, nMemWrite}, done1);
            end
        end
        tick;
        testsRun++;
        if ({done1, done0, busy, nMemOut} !== 4'b1001 || rdata !== 16'hBEEF) begin
            testsFailed++;
            $display("[TB] FAIL read_done: done1,done0,busy,nO=%b rdata=%h expected 1001/BEEF",
                     {done1, done0, busy, nMemOut}, rdata);
        end
        applyStimulus(1, 1'b0, 1'b0, 11'h0, 16'h0);
        tick;
    endtask

    task automatic test_contention;
        int order[$];
        int doneCnt;
        applyReset;
        for (int round = 0; round < 2; round++) begin
            order.delete();
            doneCnt = 0;
            applyStimulus(0, 1'b1, 1'b1, 11'h010, 16'h1111);
            applyStimulus(1, 1'b1, 1'b1, 11'h011, 16'h2222);
            for (int c = 0; c < 40; c++) begin
                tick;
                if (gnt0) order.push_back(0);
                if (gnt1) order.push_back(1);
                if (done0) begin doneCnt++; applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0); end
                if (done1) begin doneCnt++; applyStimulus(1, 1'b0, 1'b0, 11'h0, 16'h0); end
                if (doneCnt == 2) break;
            end
            tick;
            testsRun++;
            if (doneCnt != 2 || order.size() != 2) begin
                testsFailed++;
                $display("[TB] FAIL contention_r%0d_count: got %0d dones %0d grants expected 2/2",
                         round, doneCnt, order.size());
            end else begin
                testsRun++;
                if (order[0] != round || order[1] != 1 - round) begin
                    testsFailed++;
                    $display("[TB] FAIL contention_r%0d_order: got %0d,%0d expected %0d,%0d",
                             round, order[0], order[1], round, 1 - round);
                end
            end
        end
    endtask

    task automatic test_starvation;
        int order[$];
        int expOrder[4];
        bit quiet;
        expOrder = '{0, 1, 0, 1};
        applyStimulus(0, 1'b1, 1'b0, 11'h005, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 11'h005, 16'h0);
        for (int c = 0; c < 60; c++) begin
            tick;
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
            if (order.size() >= 4) break;
        end
        applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 11'h0, 16'h0);
        quiet = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (!busy && !done0 && !done1) begin quiet = 1'b1; break; end
        end
        testsRun++;
        if (order.size() != 4 || !quiet) begin
            testsFailed++;
            $display("[TB] FAIL starvation_count: got %0d grants quiet=%0d expected 4/1",
                     order.size(), quiet);
        end else begin
            for (int k = 0; k < 4; k++) begin
                testsRun++;
                if (order[k] != expOrder[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL starvation_grant%0d: got port %0d expected port %0d",
                             k, order[k], expOrder[k]);
                end
            end
        end
        testsRun++;
        if (rdata !== 16'hBEEF) begin
            testsFailed++;
            $display("[TB] FAIL starvation_rdata: got %h expected BEEF", rdata);
        end
    endtask

    task automatic test_sweep;
        bit seen;
        for (int i = 0; i < 128; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 11'(i), 16'(i));
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick;
                if (done0) begin seen = 1'b1; break; end
            end
            applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0);
            if (!seen) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL sweep_write_timeout: addr %0d got no done0 expected done0", i);
            end
        end
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 11'(i), 16'h0);
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick;
                if (done1) begin seen = 1'b1; break; end
            end
            testsRun++;
            if (!seen) begin
                testsFailed++;
                $display("[TB] FAIL sweep_read_timeout: addr %0d got no done1 expected done1", i);
            end else if (rdata !== 16'(i)) begin
                testsFailed++;
                $display("[TB] FAIL sweep_rdata: addr %0d got %h expected %h", i, rdata, 16'(i));
            end
            applyStimulus(1, 1'b0, 1'b0, 11'h0, 16'h0);
        end
        tick;
    endtask

    task automatic test_reset_mid_write;
        bit sawDone;
        applyStimulus(0, 1'b1, 1'b1, 11'h020, 16'hCAFE);
        tick;
        tick;
        testsRun++;
        if (nMemWrite !== 1'b0 || memData !== 16'hCAFE) begin
            testsFailed++;
            $display("[TB] FAIL midreset_pre: nW=%b memData=%h expected 0/CAFE", nMemWrite, memData);
        end
        rst = 1'b1;
        tick;
        testsRun++;
        if ({nMemWrite, nMemOut, busy, done0, gnt0} !== 5'b11000 || memAdd !== 11'h000) begin
            testsFailed++;
            $display("[TB] FAIL midreset_state: nW,nO,busy,done0,gnt0=%b memAdd=%h expected 11000/000",
                     {nMemWrite, nMemOut, busy, done0, gnt0}, memAdd);
        end
        probeOn = 1'b1;
        #1;
        testsRun++;
        if (memData !== 16'h1234) begin
            testsFailed++;
            $display("[TB] FAIL midreset_bus_released: got %h expected 1234", memData);
        end
        probeOn = 1'b0;
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0);
        sawDone = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (done0 || busy) sawDone = 1'b1;
        end
        testsRun++;
        if (sawDone) begin
            testsFailed++;
            $display("[TB] FAIL midreset_no_done: got done0/busy activity expected none");
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) sram[a] = 16'h0000;
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        probeOn     = 1'b0;
        rst         = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 11'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 11'h0, 16'h0);
        test_reset;
        test_write;
        test_read_back;
        test_contention;
        test_starvation;
        test_sweep;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
